// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised multi-read register file with a per-register
// busy scoreboard. Producers reserve a destination through rsv_en/rsv_addr; the
// matching writeback (w_en/w_addr) releases it. Reads are combinational.
// Optional feature: define REGFILE_BYPASS_EN to forward w_data to read ports
// that address the register being written in the same cycle.
module regfile_scoreboard #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int NREAD   = 2,
   parameter int ZERO_R0 = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      w_en,
   input  logic [ADDR_W-1:0]         w_addr,
   input  logic [DATA_W-1:0]         w_data,
   input  logic [NREAD*ADDR_W-1:0]   rd_addr,
   output logic [NREAD*DATA_W-1:0]   rd_data,
   output logic [NREAD-1:0]          rd_busy,
   input  logic                      rsv_en,
   input  logic [ADDR_W-1:0]         rsv_addr,
   output logic                      rsv_ok,
   output logic [ADDR_W:0]           busy_cnt
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;
   logic [ADDR_W:0]   busy_cnt_q;

   logic w_is_r0;
   logic rsv_is_r0;
   logic w_commit;
   logic rsv_set;
   logic busy_inc;
   logic busy_dec;

   // r0 is hard-wired only when ZERO_R0 is set; otherwise it is an ordinary register
   assign w_is_r0   = (ZERO_R0 != 0) && (w_addr == '0);
   assign rsv_is_r0 = (ZERO_R0 != 0) && (rsv_addr == '0);

   assign w_commit = w_en & ~w_is_r0;

   // A reservation is granted when the target is free or is being released this cycle
   assign rsv_ok = rsv_en & (~busy[rsv_addr] | (w_en & (w_addr == rsv_addr)));

   // The hard-wired r0 grants reservations but never records them
   assign rsv_set = rsv_ok & ~rsv_is_r0;

   // The count moves only when a busy bit actually flips, so a release and
   // re-reserve of the same register on one edge leaves it unchanged
   assign busy_inc = rsv_set & ~busy[rsv_addr];
   assign busy_dec = w_en & busy[w_addr] & ~(rsv_set & (rsv_addr == w_addr));

   // Register storage: cleared by reset, written on the edge where w_en is high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (w_commit) begin
         regs[w_addr] <= w_data;
      end
   end

   // Busy bits: writeback clears, reservation sets; the set is applied last so it wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= '0;
      end else begin
         if (w_en) begin
            busy[w_addr] <= 1'b0;
         end
         if (rsv_set) begin
            busy[rsv_addr] <= 1'b1;
         end
      end
   end

   // Running population count of the busy bits, wide enough to hold NREG
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_cnt_q <= '0;
      end else begin
         case ({busy_inc, busy_dec})
            2'b10:   busy_cnt_q <= busy_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   busy_cnt_q <= busy_cnt_q - {{ADDR_W{1'b0}}, 1'b1};
            default: busy_cnt_q <= busy_cnt_q;
         endcase
      end
   end

   assign busy_cnt = busy_cnt_q;

   // One independent combinational read mux per port
   for (genvar k = 0; k < NREAD; k++) begin : g_rd_port
      logic [ADDR_W-1:0] ra;
      logic              ra_zero;
      logic              ra_hit;

      assign ra      = rd_addr[k*ADDR_W +: ADDR_W];
      assign ra_zero = (ZERO_R0 != 0) && (ra == '0);
      assign ra_hit  = w_en & (w_addr == ra);

`ifdef REGFILE_BYPASS_EN
      assign rd_data[k*DATA_W +: DATA_W] = ra_zero ? '0 :
                                           ra_hit  ? w_data : regs[ra];
`else
      assign rd_data[k*DATA_W +: DATA_W] = ra_zero ? '0 : regs[ra];
`endif

      // A register completing this cycle already reads as free
      assign rd_busy[k] = busy[ra] & ~ra_hit;
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: randomized + directed scoreboard bench for
// regfile_scoreboard. Two instances run side by side, one with ZERO_R0=0 and
// one with ZERO_R0=1, both driven by the same stimulus. Honours REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int NREAD  = 2;
   localparam int NREG   = 16;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                     clk;
   logic                     reset;
   logic                     w_en;
   logic [ADDR_W-1:0]        w_addr;
   logic [DATA_W-1:0]        w_data;
   logic [NREAD*ADDR_W-1:0]  rd_addr;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;

   logic [NREAD*DATA_W-1:0]  rd_data_a, rd_data_z;
   logic [NREAD-1:0]         rd_busy_a, rd_busy_z;
   logic                     rsv_ok_a, rsv_ok_z;
   logic [ADDR_W:0]          busy_cnt_a, busy_cnt_z;

   regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_R0(0)) dut_a (
      .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_a), .busy_cnt(busy_cnt_a)
   );

   regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_R0(1)) dut_z (
      .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_z), .busy_cnt(busy_cnt_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs for one cycle, index 0 = ZERO_R0=0 instance, 1 = ZERO_R0=1
   typedef struct {
      logic [1:0][31:0] data;
      logic [1:0][1:0]  busy;
      logic [1:0]       ok;
      logic [1:0][4:0]  cnt;
      string            tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model: plain register contents and busy flags per instance
   logic [15:0] m_mem  [2][16];
   bit          m_busy [2][16];

   int tests_run    = 0;
   int tests_failed = 0;
   int pushed       = 0;
   int popped       = 0;

   // Drive one cycle, predict the outputs from the model, then advance the model
   task automatic apply_stimulus(input logic rst_v, input logic we, input logic [3:0] wa,
                                 input logic [15:0] wd, input logic [3:0] ra0,
                                 input logic [3:0] ra1, input logic re,
                                 input logic [3:0] rsa, input string tag);
      exp_t        e;
      int          a;
      int          cnt;
      bit          hit;
      bit          ok;
      bit          zr;
      logic [15:0] d;
      reset    = rst_v;
      w_en     = we;
      w_addr   = wa;
      w_data   = wd;
      rd_addr  = {ra1, ra0};
      rsv_en   = re;
      rsv_addr = rsa;
      if (!rst_v) begin
         for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < NREG; i++) begin
               m_mem[z][i]  = '0;
               m_busy[z][i] = 1'b0;
            end
         end
      end
      for (int z = 0; z < 2; z++) begin
         zr = (z == 1);
         for (int k = 0; k < NREAD; k++) begin
            a   = (k == 0) ? int'(ra0) : int'(ra1);
            hit = we && (int'(wa) == a);
            if (zr && a == 0)
               d = '0;
            else if (BYPASS && hit)
               d = wd;
            else
               d = m_mem[z][a];
            e.data[z][k*16 +: 16] = d;
            e.busy[z][k] = m_busy[z][a] && !hit;
         end
         ok = re && (!m_busy[z][rsa] || (we && wa == rsa));
         e.ok[z] = ok;
         cnt = 0;
         for (int i = 0; i < NREG; i++) cnt += int'(m_busy[z][i]);
         e.cnt[z] = 5'(cnt);
         if (rst_v) begin
            if (we && !(zr && wa == 4'd0)) m_mem[z][wa] = wd;
            if (we) m_busy[z][wa] = 1'b0;
            if (ok && !(zr && rsa == 4'd0)) m_busy[z][rsa] = 1'b1;
         end
      end
      e.tag = tag;
      exp_q.push_back(e);
      pushed++;
      @(posedge clk);
      #1;
   endtask

   // Single comparison: counts it and reports any difference
   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp_v, input string tag);
      tests_run++;
      if (act !== exp_v) begin
         tests_failed++;
         $display("[TB] FAIL %s %s: got 0x%0h expected 0x%0h", tag, name, act, exp_v);
      end
   endtask

   // Monitor: compares the DUT outputs against the queued prediction each cycle
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            popped++;
            check_output("a.rd_data",  32'(rd_data_a),  mon_e.data[0], mon_e.tag);
            check_output("a.rd_busy",  32'(rd_busy_a),  32'(mon_e.busy[0]), mon_e.tag);
            check_output("a.rsv_ok",   32'(rsv_ok_a),   32'(mon_e.ok[0]), mon_e.tag);
            check_output("a.busy_cnt", 32'(busy_cnt_a), 32'(mon_e.cnt[0]), mon_e.tag);
            check_output("z.rd_data",  32'(rd_data_z),  mon_e.data[1], mon_e.tag);
            check_output("z.rd_busy",  32'(rd_busy_z),  32'(mon_e.busy[1]), mon_e.tag);
            check_output("z.rsv_ok",   32'(rsv_ok_z),   32'(mon_e.ok[1]), mon_e.tag);
            check_output("z.busy_cnt", 32'(busy_cnt_z), 32'(mon_e.cnt[1]), mon_e.tag);
         end
      end
   end

   // Directed scenarios followed by a randomized run
   initial begin
      reset    = 1'b1;
      w_en     = 1'b0;
      w_addr   = '0;
      w_data   = '0;
      rd_addr  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
      #2 reset = 1'b0;
      @(posedge clk);
      #1;

      // Reset held, then released
      apply_stimulus(1'b0, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd5, 1'b0, 4'd0, "reset_hold");
      apply_stimulus(1'b0, 1'b1, 4'd3, 16'h5555, 4'd3, 4'd5, 1'b1, 4'd3, "reset_hold_drv");
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd5, 1'b0, 4'd0, "reset_release");

      // Write then read
      apply_stimulus(1'b1, 1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd5, 1'b0, 4'd0, "write_same_cycle");
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd5, 1'b0, 4'd0, "write_next_cycle");

      // Reserve and stall
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd7, 1'b1, 4'd7, "rsv_r7");
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd7, 1'b1, 4'd7, "rsv_r7_again");
      apply_stimulus(1'b1, 1'b1, 4'd7, 16'h1234, 4'd3, 4'd7, 1'b0, 4'd0, "wb_r7");
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd7, 1'b0, 4'd0, "after_wb_r7");

      // Simultaneous complete + reserve on r2
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd7, 1'b1, 4'd2, "rsv_r2");
      apply_stimulus(1'b1, 1'b1, 4'd2, 16'h0042, 4'd2, 4'd7, 1'b1, 4'd2, "wb_rsv_r2");
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd7, 1'b0, 4'd0, "after_wb_rsv_r2");

      // Write + reserve of different registers in one cycle
      apply_stimulus(1'b1, 1'b1, 4'd2, 16'h0A0A, 4'd2, 4'd9, 1'b1, 4'd9, "wb_r2_rsv_r9");
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd9, 1'b0, 4'd0, "after_wb_r2_rsv_r9");

      // Saturation: reserve every register, then try more
      for (int i = 0; i < NREG; i++) begin
         apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'(i), 4'd15, 1'b1, 4'(i), "sat_fill");
      end
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd15, 1'b1, 4'd5, "sat_full");
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd15, 1'b1, 4'd11, "sat_full2");
      apply_stimulus(1'b0, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd15, 1'b1, 4'd9, "sat_async_reset");
      apply_stimulus(1'b1, 1'b1, 4'd5, 16'h7777, 4'd5, 4'd15, 1'b0, 4'd0, "stale_wb_plain");
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd15, 1'b0, 4'd0, "after_stale_wb");

      // r0 handling: hard-wired in the ZERO_R0 instance
      apply_stimulus(1'b1, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b1, 4'd0, "r0_wr_rsv");
      apply_stimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd3, 1'b1, 4'd0, "r0_after");

      // Randomized traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         logic       rst_r;
         logic       we_r;
         logic       re_r;
         logic [3:0] wa_r;
         logic [3:0] rsa_r;
         rst_r = ($urandom_range(0, 63) != 0);
         we_r  = ($urandom_range(0, 2) == 0);
         re_r  = ($urandom_range(0, 1) == 0);
         rsa_r = 4'($urandom_range(0, 15));
         wa_r  = ($urandom_range(0, 3) == 0) ? rsa_r : 4'($urandom_range(0, 15));
         apply_stimulus(rst_r, we_r, wa_r, 16'($urandom), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), re_r, rsa_r, "random");
      end

      // Let the monitor drain, bounded
      for (int t = 0; t < 4 && exp_q.size() > 0; t++) @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0 || popped != pushed) begin
         tests_failed++;
         $display("[TB] FAIL monitor_drain: got %0d checked expected %0d issued", popped, pushed);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's 16-bit, 2-read/1-write register file.
- Generalised in data width, register count and read-port count.
- Adds a per-register busy scoreboard, so multicycle producers (ALU extensions, load unit) can reserve a destination and the decoder can stall on RAW/WAW hazards.
- Sits between the decoder (read/reserve side) and the execute/writeback stages (write side).

Parameters:
- DATA_W, 16: register data width in bits.
- ADDR_W, 4: register address width; register count NREG = 2**ADDR_W.
- NREAD, 2: number of independent read ports (1..4).
- ZERO_R0, 0: when 1, register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- w_en, input, 1: writeback strobe.
- w_addr, input, ADDR_W: writeback destination.
- w_data, input, DATA_W: writeback data.
- rd_addr, input, NREAD*ADDR_W: packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data, output, NREAD*DATA_W: packed read data, same packing.
- rd_busy, output, NREAD: busy bit of each addressed register.
- rsv_en, input, 1: request to reserve a destination register.
- rsv_addr, input, ADDR_W: register to reserve.
- rsv_ok, output, 1: reservation accepted this cycle.
- busy_cnt, output, ADDR_W+1: number of registers currently busy.

Behaviour:
- Reset (reset=0, async): all registers 0, all busy bits 0, busy_cnt 0.
  - rd_data and rd_busy reflect the cleared state combinationally.
  - rsv_ok = rsv_en & ~busy, evaluated against cleared state.
- Storage: NREG x DATA_W flops. Write occurs at the rising edge when w_en=1. Latency 1 cycle, except for bypass (see Optional Feature).
- Reads:
  - Combinational, 0 latency, one mux per port.
  - Any number of ports may address the same register.
- Busy set: on the edge where rsv_ok=1, busy[rsv_addr] <= 1.
- Busy clear: on the edge where w_en=1, busy[w_addr] <= 0.
- rsv_ok is combinational. It equals rsv_en & (~busy[rsv_addr] | (w_en & w_addr==rsv_addr)).
  - A reservation on a register being written back that same cycle is accepted.
  - On that edge set wins, so busy ends at 1 (new producer owns the register).
- Reservation on a busy register with no matching writeback gives rsv_ok=0 and no state change. The requester retries; no internal queue.
- Write to a non-busy register is legal. It updates data, busy stays 0.
- Write to one address and reservation of a different address in the same cycle: both take effect independently.
- rd_busy[k] = busy[rd_addr_k] & ~(w_en & w_addr==rd_addr_k), i.e. a register completing this cycle reads as not busy.
- busy_cnt:
  - Registered; updated each edge by +1 (set only), -1 (clear of a busy bit only), 0 otherwise.
  - Never exceeds NREG. All NREG busy must give busy_cnt = NREG without wrap, hence width ADDR_W+1.
- ZERO_R0=1:
  - Reads of r0 return 0.
  - Writes to r0 are dropped.
  - rsv_ok=rsv_en for r0, and busy is never set.
- Reset asserted mid-operation discards all reservations. Outstanding writebacks arriving after reset release are plain writes.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When w_en=1 and w_addr==rd_addr_k, rd_data port k returns w_data in the same cycle (r0 still 0 if ZERO_R0).
- Undefined: rd_data returns the stored value. New data is visible from the cycle after the write edge.
- Scoreboard behaviour is identical in both builds.

Test Plan:
- Reset: hold reset=0, drive rd_addr={3,5} -> rd_data all 0, rd_busy=0, busy_cnt=0; release, still 0.
- Write then read: w_en=1, w_addr=3, w_data=0xBEEF, rd_addr0=3 -> same cycle 0xBEEF if REGFILE_BYPASS_EN else 0x0000; next cycle 0xBEEF in both builds.
- Reserve/stall: rsv r7 -> rsv_ok=1, busy_cnt=1; rsv r7 again -> rsv_ok=0; rd_addr1=7 -> rd_busy[1]=1; write r7=0x1234 -> next cycle busy_cnt=0, rd_data1=0x1234.
- Simultaneous complete+reserve: r2 busy; same cycle w_en r2=0x0042 and rsv r2 -> rsv_ok=1, rd_busy=0 that cycle; after edge busy[2]=1, data 0x0042, busy_cnt unchanged.
- Saturation: reserve all 16 registers -> busy_cnt=16 (0x10), every further rsv_ok=0; async reset mid-sequence -> busy_cnt=0 immediately.
- ZERO_R0=1: write r0=0xFFFF, rsv r0 -> rd_data=0, rsv_ok=1, busy_cnt unchanged.
